// File: rtl/counter_controller.sv
// Run/pause/clear controller for a two-digit cascaded counter: prescaler, digit chain and LED drive.
// Optional build macro COUNTER_CTRL_AUTOSTOP_EN adds the DONE state and the TARGET stop compare.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | reset/cleared; prescaler and digits frozen
// ST_RUN   | prescaler advancing, digits count on each prescaler wrap
// ST_PAUSE | frozen mid-period; prescaler phase kept for resume
// ST_DONE  | TARGET reached (autostop build only); only cmd_clear leaves

module counter_controller #(
   parameter int unsigned PERIOD   = 25000000,
   parameter int unsigned LIMIT_LO = 10,
   parameter int unsigned LIMIT_HI = 10,
   parameter logic [7:0]  TARGET   = 8'h59
) (
   input  logic       CLK_50M,
   input  logic       RST_N,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_clear,
   output logic [7:0] LED,
   output logic       tick,
   output logic       busy,
   output logic       done
);

   localparam logic [29:0] PRESC_MAX = 30'(PERIOD - 1);
   localparam logic [3:0]  LO_MAX    = 4'(LIMIT_LO - 1);
   localparam logic [3:0]  HI_MAX    = 4'(LIMIT_HI - 1);

`ifdef COUNTER_CTRL_AUTOSTOP_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;
`endif

   state_t      r_state;
   logic [29:0] r_presc;
   logic [3:0]  r_lo;
   logic [3:0]  r_hi;
   logic        r_tick;

   state_t      w_state_nxt;
   logic [29:0] w_presc_nxt;
   logic [3:0]  w_lo_nxt;
   logic [3:0]  w_hi_nxt;
   logic        w_tick_nxt;
   logic        w_wrap;

   assign w_wrap = (r_presc == PRESC_MAX);

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_presc <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_lo    <= w_lo_nxt;
         r_hi    <= w_hi_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_lo_nxt    = r_lo;
      w_hi_nxt    = r_hi;
      w_tick_nxt  = 1'b0;

      if (cmd_clear) begin
         w_state_nxt = ST_IDLE;
         w_presc_nxt = '0;
         w_lo_nxt    = '0;
         w_hi_nxt    = '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_PAUSE: begin
               if (cmd_start)
                  w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (w_wrap) begin
                  w_presc_nxt = '0;
                  w_tick_nxt  = 1'b1;
                  if (r_lo == LO_MAX) begin
                     w_lo_nxt = '0;
                     w_hi_nxt = (r_hi == HI_MAX) ? 4'd0 : r_hi + 4'd1;
                  end else begin
                     w_lo_nxt = r_lo + 4'd1;
                  end
`ifdef COUNTER_CTRL_AUTOSTOP_EN
                  if ({w_hi_nxt, w_lo_nxt} == TARGET)
                     w_state_nxt = ST_DONE;
`endif
               end else begin
                  w_presc_nxt = r_presc + 30'd1;
               end
               // A count event on the stop edge still completes; reaching TARGET outranks the pause.
               if (cmd_stop && (w_state_nxt == ST_RUN))
                  w_state_nxt = ST_PAUSE;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   assign LED  = {r_hi, r_lo};
   assign tick = r_tick;
   assign busy = (r_state == ST_RUN);

`ifdef COUNTER_CTRL_AUTOSTOP_EN
   assign done = (r_state == ST_DONE);
`else
   logic w_unused_target;
   assign w_unused_target = ^TARGET;
   assign done = 1'b0;
`endif

endmodule

// File: tb/tb_counter_controller.sv
// Self-checking bench for counter_controller: decimal reference model feeding a scoreboard
// queue every cycle, plus a table of command steps with fixed expected end values.
module tb_counter_controller;

   localparam int unsigned PERIOD = 4;
   localparam int          TARGET_DEC = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_start = 1'b0;
   logic       s_stop = 1'b0;
   logic       s_clear = 1'b0;
   logic [7:0] led;
   logic       tick;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   counter_controller #(
      .PERIOD   (PERIOD),
      .LIMIT_LO (10),
      .LIMIT_HI (10),
      .TARGET   (8'h12)
   ) dut (
      .CLK_50M   (clk),
      .RST_N     (rst_n),
      .cmd_start (s_start),
      .cmd_stop  (s_stop),
      .cmd_clear (s_clear),
      .LED       (led),
      .tick      (tick),
      .busy      (busy),
      .done      (done)
   );

   typedef struct packed {
      logic [7:0] led;
      logic       tick;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      logic       start;
      logic       stop;
      logic       clear;
      int         wait_cyc;
      logic [7:0] led;
      logic       tick;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];
   obs_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: count kept as a decimal integer 0..99, state 0 idle 1 run 2 pause 3 done
   int   m_cnt = 0;
   int   m_phase = 0;
   int   m_st = 0;
   logic m_tick = 1'b0;

   function automatic obs_t model_out();
      obs_t o;
      o.led  = {4'(m_cnt / 10), 4'(m_cnt % 10)};
      o.tick = m_tick;
      o.busy = (m_st == 1);
      o.done = (m_st == 3);
      return o;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_phase = 0; m_st = 0; m_tick = 1'b0;
   endtask

   task automatic model_edge(input logic st, input logic sp, input logic cl);
      int old_st;
      old_st = m_st;
      m_tick = 1'b0;
      if (cl) begin
         model_reset();
      end else if (old_st == 1) begin
         if (m_phase == int'(PERIOD) - 1) begin
            m_phase = 0;
            m_tick  = 1'b1;
            m_cnt   = (m_cnt + 1) % 100;
`ifdef COUNTER_CTRL_AUTOSTOP_EN
            if (m_cnt == TARGET_DEC) m_st = 3;
`endif
         end else begin
            m_phase = m_phase + 1;
         end
         if (sp && m_st == 1) m_st = 2;
      end else if ((old_st == 0 || old_st == 2) && st) begin
         m_st = 1;
      end
   endtask

   // Called at a falling edge: drive, predict, clock, then compare against the scoreboard head.
   task automatic step(input logic st, input logic sp, input logic cl);
      obs_t got, exp;
      s_start = st; s_stop = sp; s_clear = cl;
      model_edge(st, sp, cl);
      sb.push_back(model_out());
      @(posedge clk);
      @(negedge clk);
      s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0;
      got = {led, tick, busy, done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cyc%0d got led=%h tick=%b busy=%b done=%b want led=%h tick=%b busy=%b done=%b",
                  cyc, got.led, got.tick, got.busy, got.done, exp.led, exp.tick, exp.busy, exp.done);
      end
      cyc++;
   endtask

   task automatic check_const(input string name, input logic [7:0] e_led, input logic e_tick,
                              input logic e_busy, input logic e_done);
      checks++;
      if ({led, tick, busy, done} !== {e_led, e_tick, e_busy, e_done}) begin
         errors++;
         $display("FAIL %s got led=%h tick=%b busy=%b done=%b want led=%h tick=%b busy=%b done=%b",
                  name, led, tick, busy, done, e_led, e_tick, e_busy, e_done);
      end
   endtask

   initial begin
      // start, stop, clear, extra idle cycles, then expected led/tick/busy/done
      vecs.push_back('{1'b1, 1'b0, 1'b0,  4, 8'h01, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0,  3, 8'h02, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 31, 8'h10, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0,  0, 8'h10, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 19, 8'h10, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0,  0, 8'h10, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0,  1, 8'h11, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0,  2, 8'h11, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1,  0, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0,  5, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0,  0, 8'h00, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0,  7, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0,  3, 8'h01, 1'b1, 1'b1, 1'b0});
`ifdef COUNTER_CTRL_AUTOSTOP_EN
      vecs.push_back('{1'b0, 1'b0, 1'b0, 43, 8'h12, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b0,  9, 8'h12, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0,  3, 8'h12, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1,  0, 8'h00, 1'b0, 1'b0, 1'b0});
`else
      vecs.push_back('{1'b0, 1'b0, 1'b0, 391, 8'h99, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0,   3, 8'h00, 1'b1, 1'b1, 1'b0});
`endif

      repeat (3) @(negedge clk);
      check_const("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      model_reset();

      foreach (vecs[i]) begin
         step(vecs[i].start, vecs[i].stop, vecs[i].clear);
         for (int k = 0; k < vecs[i].wait_cyc; k++) step(1'b0, 1'b0, 1'b0);
         check_const($sformatf("vec%0d", i), vecs[i].led, vecs[i].tick, vecs[i].busy, vecs[i].done);
      end

      // Asynchronous reset in the middle of a run, right after the tick that shows 07
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 100 && !(m_tick && m_cnt == 7); i++) step(1'b0, 1'b0, 1'b0);
      check_const("pre_reset_07", 8'h07, 1'b1, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1 check_const("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
      check_const("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
      check_const("restart_first_tick", 8'h01, 1'b1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_controller.md
# counter_controller

Run/pause/clear controller for the two-digit cascaded counter display. It owns the prescaler that turns CLK_50M into count ticks, sequences the low and high digit counters (low digit carry feeds the high digit), and drives LED[7:0] with {high digit, low digit}. It sits between the debounced push-button command pulses and the LED bus, replacing the free-running divider and counter chain with a commanded one.

## Interface
- PERIOD, 25000000: CLK_50M cycles per count tick; legal range 2..2^30-1.
- LIMIT_LO, 10: modulus of the low digit; legal range 2..16.
- LIMIT_HI, 10: modulus of the high digit; legal range 2..16.
- TARGET, 8'h59: {hi, lo} value that ends a run; used only with COUNTER_CTRL_AUTOSTOP_EN.
- CLK_50M  input  1  system clock, 50 MHz; all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- cmd_start  input  1  one-cycle pulse, synchronous to CLK_50M, already debounced.
- cmd_stop  input  1  one-cycle pulse, synchronous to CLK_50M, already debounced.
- cmd_clear  input  1  one-cycle pulse, synchronous to CLK_50M, already debounced.
- LED  output  8  {hi[3:0], lo[3:0]}, registered.
- tick  output  1  one-cycle pulse on every count increment, registered.
- busy  output  1  high while the state is RUN.
- done  output  1  high while the state is DONE. Tied to 0 without COUNTER_CTRL_AUTOSTOP_EN.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - PAUSE.
  - DONE: exists only with COUNTER_CTRL_AUTOSTOP_EN.
- Reset (RST_N low), applied asynchronously:
  - state = IDLE.
  - prescaler = 0, lo = 0, hi = 0, so LED = 8'h00.
  - tick = 0, busy = 0, done = 0.
  - Reset asserted mid-run aborts the run immediately; no tick is pending after release.
- Command priority when several pulses arrive in the same cycle: clear > stop > start.
- cmd_clear, any state:
  - prescaler, lo and hi go to 0.
  - state goes to IDLE.
  - Any tick that would have fired on that edge is suppressed.
- cmd_start:
  - IDLE or PAUSE -> RUN.
  - Ignored in RUN and in DONE; DONE requires cmd_clear first.
- cmd_stop:
  - RUN -> PAUSE.
  - Ignored in all other states.
  - The prescaler holds its value, so resuming keeps the tick phase.
- Prescaler (30-bit) in RUN:
  - Increments every cycle.
  - When it equals PERIOD-1 it wraps to 0 and a count event occurs.
  - Frozen in every other state.
- Count event:
  - If lo == LIMIT_LO-1: lo = 0 and hi = (hi == LIMIT_HI-1) ? 0 : hi+1.
  - Otherwise: lo = lo+1.
  - Arithmetic is 4-bit unsigned; lo and hi never exceed their limit minus 1.
- Autostop (with macro only):
  - If the post-increment {hi, lo} equals TARGET, state goes to DONE on the same edge.
  - In DONE: LED holds TARGET and the prescaler freezes.
- Stop and count event in the same cycle: the count event completes (LED updates, tick fires), then the state becomes PAUSE.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Command latency: a command sampled at edge k changes busy and done after edge k.
- First increment after cmd_start from IDLE at edge k:
  - LED updates at edge k+PERIOD.
  - tick is high for the single cycle following edge k+PERIOD.
- Steady state: one tick every PERIOD cycles; the tick edge coincides with the LED update edge.
- Resume from PAUSE: the next tick arrives at PERIOD minus (prescaler value at pause) cycles after the start edge.
- Wrap-around: {hi, lo} = {LIMIT_HI-1, LIMIT_LO-1} goes to 8'h00 on the next count event.
  - With the macro, this applies unless the current value is TARGET.

## Configuration
- COUNTER_CTRL_AUTOSTOP_EN defined:
  - The DONE state and the TARGET comparison are built.
  - done asserts when the count reaches TARGET; leaving DONE requires cmd_clear.
- COUNTER_CTRL_AUTOSTOP_EN undefined:
  - No DONE state and no comparator; done is constant 0.
  - The counter runs and wraps indefinitely until stopped or cleared.

## Test plan
Bench configuration for all scenarios: PERIOD=4, LIMIT_LO=10, LIMIT_HI=10, TARGET=8'h12.
- Reset, then cmd_start at edge 0:
  - LED = 8'h01 and tick high after edge 4.
  - LED = 8'h02 after edge 8.
  - busy = 1 from edge 0.
- Carry: run to LED = 8'h09, next tick gives 8'h10. Without the macro: from 8'h99 the next tick gives 8'h00.
- Pause/resume:
  - cmd_stop two cycles after a tick: LED and prescaler freeze and busy = 0 for 20 cycles.
  - cmd_start: the next tick arrives 2 cycles later.
- Simultaneous commands:
  - cmd_clear + cmd_start in RUN: state IDLE, LED = 8'h00, no tick.
  - cmd_stop + cmd_start in RUN: state PAUSE.
- Autostop (macro defined):
  - At LED = 8'h12, done = 1, busy = 0 and no further ticks.
  - cmd_start is ignored; cmd_clear returns to IDLE with LED = 8'h00.
- Asynchronous reset:
  - Drop RST_N mid-cycle in RUN at LED = 8'h07: LED = 8'h00, tick = 0 and busy = 0 immediately, without waiting for a clock edge.
  - After release, nothing changes until cmd_start.
